ternary_matmul_ctrl: RTL
========================

Name: ternary_matmul_ctrl

Overview:
Command-driven sequencer for one ternary matrix-vector product, y = W·x.
- Per command: fetches the fixed-point vector x once, then for each of the D matrix rows fetches the row and runs the shared ternary dot-product unit on it.
- Collects the D fixed_point_t results into a vector_t and issues a single writeback.
- Sits between the AFU command decoder and the DDR read/write shims / dot-product datapath.

Parameters:
D, config_pkg::D, vector length and number of matrix rows
RowStrideBytes, (D*2+7)/8, byte distance between consecutive ternary matrix rows in DDR

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  command offered
cmd_ready_o  out  1  controller idle, accepts command
cmd_matrix_addr_i  in  DdrAddressWidth  base address of row 0
cmd_vector_addr_i  in  DdrAddressWidth  address of x
cmd_result_addr_i  in  DdrAddressWidth  address for y
rd_req_valid_o  out  1  read request
rd_req_ready_i  in  1  read request accepted
rd_req_addr_o  out  DdrAddressWidth  read address
rd_req_kind_o  out  1  0=vector, 1=matrix row
vec_rsp_valid_i  in  1  vector data valid (single-cycle)
vec_rsp_i  in  vector_t  vector data
row_rsp_valid_i  in  1  row data valid (single-cycle)
row_rsp_i  in  ternary_row_t  row data
dot_start_o  out  1  one-cycle start pulse to dot unit
dot_row_o  out  ternary_row_t  latched row
dot_vec_o  out  vector_t  latched x
dot_done_i  in  1  dot result valid (single-cycle)
dot_result_i  in  fixed_point_t  dot result
wr_valid_o  out  1  writeback request
wr_ready_i  in  1  writeback accepted
wr_addr_o  out  DdrAddressWidth  writeback address
wr_data_o  out  vector_t  result vector y
busy_o  out  1  not IDLE
done_o  out  1  one-cycle pulse, command complete
proto_err_o  out  1  sticky: unexpected response/done seen; cleared by reset only

Behaviour:
- Reset values: state=IDLE, row index=0, all valid/start/done outputs 0, proto_err_o=0, latched x/row/y/addresses=0; cmd_ready_o=1 one cycle after reset deasserts.
- States: IDLE, VEC_REQ, VEC_WAIT, ROW_REQ, ROW_WAIT, DOT_START, DOT_WAIT, WRITE, DONE.
- IDLE: cmd_ready_o=1. On cmd_valid_i: latch the three addresses, row=0, go VEC_REQ.
- VEC_REQ: rd_req_valid_o=1, kind=0, addr=vector addr. Addr/kind held stable until rd_req_ready_i, then VEC_WAIT.
- VEC_WAIT: on vec_rsp_valid_i latch x, go ROW_REQ.
- ROW_REQ: rd_req_valid_o=1, kind=1, addr=matrix_addr+row*RowStrideBytes, modulo 2^DdrAddressWidth (wrap, no error). On ready, go ROW_WAIT.
- ROW_WAIT: on row_rsp_valid_i latch row, go DOT_START.
- DOT_START: dot_start_o=1 for exactly one cycle, go DOT_WAIT. dot_row_o/dot_vec_o stay stable from DOT_START until dot_done_i.
- DOT_WAIT: on dot_done_i store dot_result_i into y[row]. If row==D-1 go WRITE, else row++ and go ROW_REQ.
- WRITE: wr_valid_o=1, wr_addr_o=result addr, wr_data_o=y, all held until wr_ready_i, then DONE.
- DONE: done_o=1 for one cycle, go IDLE.
- Ordering: exactly one outstanding read; no prefetch. y is overwritten element-by-element and holds its last value in IDLE.
- Unexpected events set proto_err_o and are otherwise ignored (no state change):
  - vec_rsp_valid_i outside VEC_WAIT
  - row_rsp_valid_i outside ROW_WAIT
  - dot_done_i outside DOT_WAIT
  - dot_done_i in the same cycle as dot_start_o
- Stalls: unbounded wait on any ready/valid; no timeout.
- Reset mid-operation: next cycle is IDLE with reset values; any in-flight request is dropped without completion. Responses arriving after reset set proto_err_o.
- Command while busy: cmd_ready_o=0; the command is not consumed.

Decomposition:
- config_pkg additions:
  - ternary_row_t (D × ternary_t)
  - ddr_addr_t (DdrAddressWidth bits)
  - RowStrideBytes default constant
  - ctrl_state_e enum
- Single module. Address generation (one multiply-by-constant adder) and result collection stay inline; no sub-module warranted.

Test Plan:
- D=4, matrix=0x1000, vector=0x2000, result=0x3000; all ready=1, responses 1 cycle after handshake, dot_done 2 cycles after start returning 0x0011,0x0022,0x0033,0x0044 -> read addrs 0x2000(k0), 0x1000, 0x1001, 0x1002, 0x1003(k1); single write to 0x3000 with y={0x0011,0x0022,0x0033,0x0044}; one done_o pulse; proto_err_o=0.
- Same command with rd_req_ready_i low for 5 cycles on each request and wr_ready_i low for 3 cycles -> addr/kind/data held stable while valid; identical results.
- matrix_addr=all-ones minus 1 -> row addresses wrap to 0x...FFFE, 0x...FFFF, 0x0, 0x1.
- Second cmd_valid_i during ROW_WAIT -> cmd_ready_o=0, command ignored; accepted in the cycle after done_o.
- rst_i asserted in DOT_WAIT of row 2, then a late dot_done_i -> IDLE, all outputs at reset values, proto_err_o=1, no write issued.
- Spurious row_rsp_valid_i in IDLE -> proto_err_o=1, state stays IDLE, busy_o=0.

Source files
------------

// File: rtl/ternary_matmul_ctrl_pkg.sv
// Shared configuration and types for the ternary matrix-vector controller.
package ternary_matmul_ctrl_pkg;

   localparam int D               = 4;
   localparam int DdrAddressWidth = 32;
   localparam int FixedPointWidth = 16;
   localparam int RowStrideBytes  = (D * 2 + 7) / 8;

   typedef logic [1:0]                 ternary_t;
   typedef logic [FixedPointWidth-1:0] fixed_point_t;
   typedef fixed_point_t [D-1:0]       vector_t;
   typedef ternary_t [D-1:0]           ternary_row_t;
   typedef logic [DdrAddressWidth-1:0] ddr_addr_t;

   typedef enum logic [3:0] {
      IDLE,
      VEC_REQ,
      VEC_WAIT,
      ROW_REQ,
      ROW_WAIT,
      DOT_START,
      DOT_WAIT,
      WRITE,
      DONE
   } ctrl_state_e;

endpackage

// File: rtl/ternary_matmul_ctrl.sv
// Sequencer for one ternary matrix-vector product y = W*x: fetch x once, then
// per row fetch the row, run the shared dot unit, collect results, write y back.
module ternary_matmul_ctrl #(
   parameter int D              = ternary_matmul_ctrl_pkg::D,
   parameter int RowStrideBytes = ternary_matmul_ctrl_pkg::RowStrideBytes
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 cmd_valid_i,
   output logic                                 cmd_ready_o,
   input  ternary_matmul_ctrl_pkg::ddr_addr_t    cmd_matrix_addr_i,
   input  ternary_matmul_ctrl_pkg::ddr_addr_t    cmd_vector_addr_i,
   input  ternary_matmul_ctrl_pkg::ddr_addr_t    cmd_result_addr_i,
   output logic                                 rd_req_valid_o,
   input  logic                                 rd_req_ready_i,
   output ternary_matmul_ctrl_pkg::ddr_addr_t    rd_req_addr_o,
   output logic                                 rd_req_kind_o,
   input  logic                                 vec_rsp_valid_i,
   input  ternary_matmul_ctrl_pkg::vector_t      vec_rsp_i,
   input  logic                                 row_rsp_valid_i,
   input  ternary_matmul_ctrl_pkg::ternary_row_t row_rsp_i,
   output logic                                 dot_start_o,
   output ternary_matmul_ctrl_pkg::ternary_row_t dot_row_o,
   output ternary_matmul_ctrl_pkg::vector_t      dot_vec_o,
   input  logic                                 dot_done_i,
   input  ternary_matmul_ctrl_pkg::fixed_point_t dot_result_i,
   output logic                                 wr_valid_o,
   input  logic                                 wr_ready_i,
   output ternary_matmul_ctrl_pkg::ddr_addr_t    wr_addr_o,
   output ternary_matmul_ctrl_pkg::vector_t      wr_data_o,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 proto_err_o
);
   import ternary_matmul_ctrl_pkg::*;

   localparam int RowW = (D > 1) ? $clog2(D) : 1;

   ctrl_state_e     state_q, state_d;
   logic [RowW-1:0] row_q, row_d;
   ddr_addr_t       matrix_addr_q, matrix_addr_d;
   ddr_addr_t       vector_addr_q, vector_addr_d;
   ddr_addr_t       result_addr_q, result_addr_d;
   vector_t         x_q, x_d;
   ternary_row_t    row_data_q, row_data_d;
   vector_t         y_q, y_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            busy_q, busy_d;
   logic            rd_req_valid_q, rd_req_valid_d;
   logic            rd_req_kind_q, rd_req_kind_d;
   ddr_addr_t       rd_req_addr_q, rd_req_addr_d;
   logic            dot_start_q, dot_start_d;
   logic            wr_valid_q, wr_valid_d;
   logic            done_q, done_d;
   logic            proto_err_q, proto_err_d;

   // Next-state, datapath latching and registered-output decode from the next state.
   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      matrix_addr_d = matrix_addr_q;
      vector_addr_d = vector_addr_q;
      result_addr_d = result_addr_q;
      x_d           = x_q;
      row_data_d    = row_data_q;
      y_d           = y_q;

      // Stray responses are flagged but never steer the FSM. DOT_START is not
      // DOT_WAIT, so a done coinciding with the start pulse is caught here too.
      proto_err_d = proto_err_q
                  | (vec_rsp_valid_i && (state_q != VEC_WAIT))
                  | (row_rsp_valid_i && (state_q != ROW_WAIT))
                  | (dot_done_i      && (state_q != DOT_WAIT));

      case (state_q)
         IDLE: begin
            // cmd_ready_q gates acceptance so the first post-reset cycle refuses commands.
            if (cmd_valid_i && cmd_ready_q) begin
               matrix_addr_d = cmd_matrix_addr_i;
               vector_addr_d = cmd_vector_addr_i;
               result_addr_d = cmd_result_addr_i;
               row_d         = '0;
               state_d       = VEC_REQ;
            end
         end
         VEC_REQ:   if (rd_req_ready_i) state_d = VEC_WAIT;
         VEC_WAIT: begin
            if (vec_rsp_valid_i) begin
               x_d     = vec_rsp_i;
               state_d = ROW_REQ;
            end
         end
         ROW_REQ:   if (rd_req_ready_i) state_d = ROW_WAIT;
         ROW_WAIT: begin
            if (row_rsp_valid_i) begin
               row_data_d = row_rsp_i;
               state_d    = DOT_START;
            end
         end
         DOT_START: state_d = DOT_WAIT;
         DOT_WAIT: begin
            if (dot_done_i) begin
               y_d[row_q] = dot_result_i;
               if (row_q == RowW'(D - 1)) begin
                  state_d = WRITE;
               end else begin
                  row_d   = row_q + RowW'(1);
                  state_d = ROW_REQ;
               end
            end
         end
         WRITE:     if (wr_ready_i) state_d = DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase

      cmd_ready_d    = (state_d == IDLE);
      busy_d         = (state_d != IDLE);
      rd_req_valid_d = (state_d == VEC_REQ) || (state_d == ROW_REQ);
      rd_req_kind_d  = (state_d == ROW_REQ);
      // Row address wraps modulo the address width; no overflow detection.
      rd_req_addr_d  = rd_req_kind_d
                     ? matrix_addr_d + ddr_addr_t'(row_d) * ddr_addr_t'(RowStrideBytes)
                     : vector_addr_d;
      dot_start_d    = (state_d == DOT_START);
      wr_valid_d     = (state_d == WRITE);
      done_d         = (state_d == DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         row_q          <= '0;
         matrix_addr_q  <= '0;
         vector_addr_q  <= '0;
         result_addr_q  <= '0;
         x_q            <= '0;
         row_data_q     <= '0;
         y_q            <= '0;
         cmd_ready_q    <= 1'b0;
         busy_q         <= 1'b0;
         rd_req_valid_q <= 1'b0;
         rd_req_kind_q  <= 1'b0;
         rd_req_addr_q  <= '0;
         dot_start_q    <= 1'b0;
         wr_valid_q     <= 1'b0;
         done_q         <= 1'b0;
         proto_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         matrix_addr_q  <= matrix_addr_d;
         vector_addr_q  <= vector_addr_d;
         result_addr_q  <= result_addr_d;
         x_q            <= x_d;
         row_data_q     <= row_data_d;
         y_q            <= y_d;
         cmd_ready_q    <= cmd_ready_d;
         busy_q         <= busy_d;
         rd_req_valid_q <= rd_req_valid_d;
         rd_req_kind_q  <= rd_req_kind_d;
         rd_req_addr_q  <= rd_req_addr_d;
         dot_start_q    <= dot_start_d;
         wr_valid_q     <= wr_valid_d;
         done_q         <= done_d;
         proto_err_q    <= proto_err_d;
      end
   end

   assign cmd_ready_o    = cmd_ready_q;
   assign busy_o         = busy_q;
   assign rd_req_valid_o = rd_req_valid_q;
   assign rd_req_kind_o  = rd_req_kind_q;
   assign rd_req_addr_o  = rd_req_addr_q;
   assign dot_start_o    = dot_start_q;
   assign dot_row_o      = row_data_q;
   assign dot_vec_o      = x_q;
   assign wr_valid_o     = wr_valid_q;
   assign wr_addr_o      = result_addr_q;
   assign wr_data_o      = y_q;
   assign done_o         = done_q;
   assign proto_err_o    = proto_err_q;

endmodule
